// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory access controller: widths, FSM states,
// memMode encodings and access-size helpers.
package common;

   typedef logic [63:0] u64;
   typedef logic [7:0]  u8;
   typedef logic [3:0]  u4;
   typedef logic [2:0]  u3;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } stateT;

   localparam u4 modeB  = 4'b0000;
   localparam u4 modeH  = 4'b0001;
   localparam u4 modeW  = 4'b0010;
   localparam u4 modeD  = 4'b0011;
   localparam u4 modeBu = 4'b0100;
   localparam u4 modeHu = 4'b0101;
   localparam u4 modeWu = 4'b0110;

   // Undefined encodings (0111 and up) fall back to doubleword.
   function automatic u3 sizeOf(input u4 mode);
      return (mode >= 4'd7) ? 3'd3 : {1'b0, mode[1:0]};
   endfunction

   function automatic logic isMisaligned(input u3 off, input u4 mode);
      logic mis;
      mis = 1'b0;
      unique case (1'b1)
         (sizeOf(mode) == 3'd1): mis = off[0];
         (sizeOf(mode) == 3'd2): mis = |off[1:0];
         (sizeOf(mode) == 3'd3): mis = |off;
         default:                mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic u8 byteMask(input u3 size);
      u8 m;
      m = 8'h01;
      unique case (1'b1)
         (size == 3'd1): m = 8'h03;
         (size == 3'd2): m = 8'h0F;
         (size == 3'd3): m = 8'hFF;
         default:        m = 8'h01;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_solver.sv
// memorySolver: extracts and extends a load result from a bus word.
// Ports: byteOff (addr[2:0]), rdata (bus word), memMode, data (result).
module memorySolver
   import common::*;
(
   input  u3  byteOff,
   input  u64 rdata,
   input  u4  memMode,
   output u64 data
);

   u64 shifted;

   assign shifted = rdata >> {byteOff, 3'b000};

   always_comb begin
      data = shifted;
      unique case (1'b1)
         (memMode == modeB):  data = {{56{shifted[7]}}, shifted[7:0]};
         (memMode == modeH):  data = {{48{shifted[15]}}, shifted[15:0]};
         (memMode == modeW):  data = {{32{shifted[31]}}, shifted[31:0]};
         (memMode == modeBu): data = {56'd0, shifted[7:0]};
         (memMode == modeHu): data = {48'd0, shifted[15:0]};
         (memMode == modeWu): data = {32'd0, shifted[31:0]};
         default:             data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-op-at-a-time load/store controller (IDLE/BUS/RESP).
// Ports: req_* pipeline request, flush, dbus_* memory bus, resp_* result.
module mem_access_ctrl
   import common::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  u64   req_addr,
   input  u64   req_wdata,
   input  u4    req_memMode,
   input  logic req_isStore,
   input  logic flush,
   output logic dbus_valid,
   output u64   dbus_addr,
   output u3    dbus_size,
   output u8    dbus_strobe,
   output u64   dbus_wdata,
   input  logic dbus_ok,
   input  u64   dbus_rdata,
   output logic resp_valid,
   output u64   resp_data,
   output logic resp_misalign
);

   stateT state;
   u64    addrReg;
   u64    wdataReg;
   u64    rdataReg;
   u4     modeReg;
   logic  storeReg;
   logic  misReg;
   logic  dropFlag;
   logic  accept;
   logic  reqMis;
   logic  busStore;
   u3     size;
   u64    solved;

   // A flush in the accept cycle blocks acceptance outright.
   assign accept = req_valid && (state == IDLE) && !flush;
   assign reqMis = isMisaligned(req_addr[2:0], req_memMode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addrReg  <= '0;
         wdataReg <= '0;
         rdataReg <= '0;
         modeReg  <= '0;
         storeReg <= 1'b0;
         misReg   <= 1'b0;
         dropFlag <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               dropFlag <= 1'b0;
               if (accept) begin
                  addrReg  <= req_addr;
                  wdataReg <= req_wdata;
                  modeReg  <= req_memMode;
                  storeReg <= req_isStore;
                  misReg   <= reqMis;
                  rdataReg <= '0;
                  state    <= reqMis ? RESP : BUS;
               end
            end
            BUS: begin
               // The bus op runs to completion; only its response is dropped.
               if (flush) dropFlag <= 1'b1;
               if (dbus_ok) begin
                  rdataReg <= dbus_rdata;
                  state    <= RESP;
               end
            end
            RESP: begin
               dropFlag <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign size     = sizeOf(modeReg);
   assign busStore = (state == BUS) && storeReg;

   assign req_ready   = (state == IDLE);
   assign dbus_valid  = (state == BUS);
   assign dbus_addr   = addrReg;
   assign dbus_size   = size;
   assign dbus_strobe = busStore ? (byteMask(size) << addrReg[2:0]) : '0;
   assign dbus_wdata  = busStore ? (wdataReg << {addrReg[2:0], 3'b000}) : '0;

   memorySolver uSolver (
      .byteOff (addrReg[2:0]),
      .rdata   (rdataReg),
      .memMode (modeReg),
      .data    (solved)
   );

   assign resp_valid    = (state == RESP) && !dropFlag && !flush;
   assign resp_misalign = resp_valid && misReg;
   assign resp_data     = ((state == RESP) && !misReg && !storeReg) ? solved : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a per-cycle expectation model.
// Expectations come from the access rules, not from the RTL structure.
module tb_mem_access_ctrl;
   import common::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0;
   logic req_ready;
   u64   req_addr = '0;
   u64   req_wdata = '0;
   u4    req_memMode = '0;
   logic req_isStore = 1'b0;
   logic flush = 1'b0;
   logic dbus_valid;
   u64   dbus_addr;
   u3    dbus_size;
   u8    dbus_strobe;
   u64   dbus_wdata;
   logic dbus_ok = 1'b0;
   u64   dbus_rdata = '0;
   logic resp_valid;
   u64   resp_data;
   logic resp_misalign;

   mem_access_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_memMode   (req_memMode),
      .req_isStore   (req_isStore),
      .flush         (flush),
      .dbus_valid    (dbus_valid),
      .dbus_addr     (dbus_addr),
      .dbus_size     (dbus_size),
      .dbus_strobe   (dbus_strobe),
      .dbus_wdata    (dbus_wdata),
      .dbus_ok       (dbus_ok),
      .dbus_rdata    (dbus_rdata),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .resp_misalign (resp_misalign)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   bit eReady, eDv, eRv, eMis, chkResp, chkEn;
   u64 eAddr, eWdata, eData;
   u3  eSize;
   u8  eStrobe;
   u64 lastResp, lastWdata;
   u8  lastStrobe;
   u3  lastSize;

   task automatic chk(input string name, input u64 act, input u64 exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mSize(input u4 m);
      return (int'(m) >= 7) ? 3 : int'(m) % 4;
   endfunction

   function automatic u64 mLoad(input u64 a, input u64 rd, input u4 m);
      int n;
      u64 v, mask;
      n = 1 << mSize(m);
      v = rd >> (8 * int'(a[2:0]));
      if (n < 8) begin
         mask = (64'd1 << (8 * n)) - 64'd1;
         v = v & mask;
         if (int'(m) <= 2 && v[8*n-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic setIdle();
      eReady = 1'b1; eDv = 1'b0; eRv = 1'b0;
      chkResp = 1'b1; eData = '0; eMis = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chkEn) begin
         chk("req_ready", u64'(req_ready), u64'(eReady));
         chk("dbus_valid", u64'(dbus_valid), u64'(eDv));
         chk("resp_valid", u64'(resp_valid), u64'(eRv));
         if (eDv) begin
            chk("dbus_addr", dbus_addr, eAddr);
            chk("dbus_size", u64'(dbus_size), u64'(eSize));
            chk("dbus_strobe", u64'(dbus_strobe), u64'(eStrobe));
            chk("dbus_wdata", dbus_wdata, eWdata);
            lastStrobe = dbus_strobe;
            lastWdata  = dbus_wdata;
            lastSize   = dbus_size;
         end
         if (chkResp) begin
            chk("resp_data", resp_data, eData);
            chk("resp_misalign", u64'(resp_misalign), u64'(eMis));
         end
         if (resp_valid) lastResp = resp_data;
      end
   end

   task automatic runOp(input u64 a, input u64 wd, input u64 rd,
                        input u4 m, input bit st, input int okDelay,
                        input bit flBus, input bit flResp);
      int sz, off;
      bit mis;
      sz  = mSize(m);
      off = int'(a[2:0]);
      mis = (off % (1 << sz)) != 0;
      req_valid = 1'b1; req_addr = a; req_wdata = wd;
      req_memMode = m; req_isStore = st;
      setIdle();
      step();
      req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd;
      req_memMode = 4'b0000; req_isStore = ~st;
      if (!mis) begin
         for (int d = 0; d <= okDelay; d++) begin
            eReady = 1'b0; eDv = 1'b1; eRv = 1'b0; chkResp = 1'b0;
            eAddr = a; eSize = u3'(sz);
            eStrobe = st ? u8'(((1 << (1 << sz)) - 1) << off) : 8'h00;
            eWdata = st ? (wd << (8 * off)) : 64'd0;
            dbus_rdata = (d == okDelay) ? rd : ~rd;
            dbus_ok = (d == okDelay);
            flush = flBus && (d == 0);
            step();
         end
         dbus_ok = 1'b0; flush = 1'b0;
         dbus_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      end
      eReady = 1'b0; eDv = 1'b0;
      flush = flResp;
      eRv = !(flBus || flResp);
      chkResp = eRv;
      eMis = mis;
      eData = (mis || st) ? 64'd0 : mLoad(a, rd, m);
      step();
      flush = 1'b0;
      setIdle();
   endtask

   initial begin
      setIdle();
      chkEn = 1'b1;
      #1;
      chk("rst_ready", u64'(req_ready), 64'd1);
      chk("rst_dbus_valid", u64'(dbus_valid), 64'd0);
      chk("rst_strobe", u64'(dbus_strobe), 64'd0);
      chk("rst_resp_data", resp_data, 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      runOp(64'h1003, 64'd0, 64'h0000_0000_8000_0000, modeB, 1'b0, 0, 1'b0, 1'b0);
      chk("lb_pin", lastResp, 64'hFFFF_FFFF_FFFF_FF80);

      runOp(64'h2006, 64'hBEEF, 64'd0, modeH, 1'b1, 0, 1'b0, 1'b0);
      chk("sh_strobe_pin", u64'(lastStrobe), 64'hC0);
      chk("sh_wdata_pin", lastWdata, 64'hBEEF_0000_0000_0000);
      chk("sh_size_pin", u64'(lastSize), 64'd1);

      runOp(64'h3002, 64'd0, 64'd0, modeW, 1'b0, 0, 1'b0, 1'b0);
      runOp(64'h4008, 64'd0, 64'h1122_3344_5566_7788, modeD, 1'b0, 5, 1'b0, 1'b0);
      chk("ld_pin", lastResp, 64'h1122_3344_5566_7788);

      runOp(64'h5002, 64'd0, 64'h0000_0000_8001_0000, modeHu, 1'b0, 1, 1'b0, 1'b0);
      chk("lhu_pin", lastResp, 64'h8001);
      runOp(64'h5002, 64'd0, 64'h0000_0000_8001_0000, modeH, 1'b0, 0, 1'b0, 1'b0);
      chk("lh_pin", lastResp, 64'hFFFF_FFFF_FFFF_8001);
      runOp(64'h6004, 64'd0, 64'hF000_0000_0000_0000, modeWu, 1'b0, 0, 1'b0, 1'b0);
      chk("lwu_pin", lastResp, 64'h0000_0000_F000_0000);
      runOp(64'h6004, 64'd0, 64'hF000_0000_0000_0000, modeW, 1'b0, 2, 1'b0, 1'b0);
      runOp(64'h7007, 64'd0, 64'hAB00_0000_0000_0000, modeBu, 1'b0, 0, 1'b0, 1'b0);
      chk("lbu_pin", lastResp, 64'hAB);

      runOp(64'h8000, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 4'b1010, 1'b0, 0, 1'b0, 1'b0);
      runOp(64'h8004, 64'd0, 64'd0, 4'b1111, 1'b0, 0, 1'b0, 1'b0);
      runOp(64'h9004, 64'h1234_5678, 64'd0, modeW, 1'b1, 1, 1'b0, 1'b0);
      chk("sw_strobe_pin", u64'(lastStrobe), 64'hF0);
      runOp(64'hA000, 64'hCAFE_BABE_1234_5678, 64'd0, modeD, 1'b1, 0, 1'b0, 1'b0);
      runOp(64'hA001, 64'h7F, 64'd0, modeB, 1'b1, 0, 1'b0, 1'b0);

      runOp(64'hB010, 64'd0, 64'h55, modeD, 1'b0, 2, 1'b1, 1'b0);
      runOp(64'hB011, 64'd0, 64'hFF00, modeB, 1'b0, 0, 1'b0, 1'b0);
      runOp(64'hC000, 64'd0, 64'h77, modeD, 1'b0, 0, 1'b0, 1'b1);
      runOp(64'hC001, 64'd0, 64'd0, modeH, 1'b0, 0, 1'b0, 1'b1);

      req_valid = 1'b1; req_addr = 64'hD000; req_memMode = modeD;
      req_isStore = 1'b0; flush = 1'b1;
      setIdle();
      step();
      req_valid = 1'b0; flush = 1'b0;
      step();

      dbus_ok = 1'b1; dbus_rdata = 64'h1;
      step();
      dbus_ok = 1'b0;
      step();

      req_valid = 1'b1; req_addr = 64'hE000; req_memMode = modeD;
      req_isStore = 1'b0;
      setIdle();
      step();
      req_valid = 1'b0;
      eReady = 1'b0; eDv = 1'b1; eRv = 1'b0; chkResp = 1'b0;
      eAddr = 64'hE000; eSize = 3'd3; eStrobe = 8'h00; eWdata = 64'd0;
      step();
      setIdle();
      rst_n = 1'b0;
      #1;
      chk("midbus_rst_dbus_valid", u64'(dbus_valid), 64'd0);
      chk("midbus_rst_ready", u64'(req_ready), 64'd1);
      step(); step();
      rst_n = 1'b1;
      step(); step(); step();

      runOp(64'hF002, 64'd0, 64'h0000_0000_1234_0000, modeH, 1'b0, 0, 1'b0, 1'b0);
      chk("post_rst_pin", lastResp, 64'h1234);

      chkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
